// File: rtl/mem_scoreboard_pkg.sv
// Shared state encoding, limits and width helper for the memory-write scoreboard.
package mem_scoreboard_pkg;

  localparam int MAX_EXP = 16;
  localparam int WCNT_W  = 16;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_RUN  = 2'd1,
    SB_PASS = 2'd2,
    SB_FAIL = 2'd3
  } sb_state_e;

  // Never returns 0 so that single-entry tables still get a 1-bit index/counter.
  function automatic int clog2_sat(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/sb_match_unit.sv
// Combinational compare of one observed write against the latched expected table.
module sb_match_unit
  import mem_scoreboard_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4,
  parameter int ORDERED = 1,
  parameter int IDX_W   = clog2_sat(NUM_EXP)
) (
  input  logic [NUM_EXP*ADDR_W-1:0] tbl_addr_i,
  input  logic [NUM_EXP*DATA_W-1:0] tbl_data_i,
  input  logic [NUM_EXP-1:0]        mask_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic [ADDR_W-1:0]         wr_addr_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  output logic                      hit_o,
  output logic [IDX_W-1:0]          hit_idx_o,
  output logic                      addr_conflict_o
);

  localparam int N_CMP = (NUM_EXP < MAX_EXP) ? NUM_EXP : MAX_EXP;

  logic addr_seen;

  always_comb begin
    hit_o           = 1'b0;
    hit_idx_o       = '0;
    addr_conflict_o = 1'b0;
    addr_seen       = 1'b0;
    if (ORDERED != 0) begin
      for (int i = 0; i < N_CMP; i++) begin
        if (IDX_W'(i) == idx_i && wr_addr_i == tbl_addr_i[i*ADDR_W +: ADDR_W]) begin
          hit_o           = (wr_data_i == tbl_data_i[i*DATA_W +: DATA_W]);
          addr_conflict_o = (wr_data_i != tbl_data_i[i*DATA_W +: DATA_W]);
          hit_idx_o       = idx_i;
        end
      end
    end else begin
      // Walk downwards so the lowest matching index is the one left standing.
      for (int i = N_CMP - 1; i >= 0; i--) begin
        if (!mask_i[i] && wr_addr_i == tbl_addr_i[i*ADDR_W +: ADDR_W]) begin
          addr_seen = 1'b1;
          if (wr_data_i == tbl_data_i[i*DATA_W +: DATA_W]) begin
            hit_o     = 1'b1;
            hit_idx_o = IDX_W'(i);
          end
        end
      end
      addr_conflict_o = addr_seen && !hit_o;
    end
  end

endmodule

// File: rtl/mem_write_scoreboard.sv
// Watches the core's data-memory write port and checks writes against a latched table of
// expected (address, data) pairs, reporting sticky pass / fail / timeout status.
//
// state   | meaning
// SB_IDLE | disarmed, all status cleared, waiting for start
// SB_RUN  | armed, matching writes and counting cycles
// SB_PASS | every entry matched; holds until start/abort
// SB_FAIL | mismatch or timeout; holds until start/abort
module mem_write_scoreboard
  import mem_scoreboard_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_EXP     = 4,
  parameter int TIMEOUT_CYC = 500,
  parameter int ORDERED     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_EXP*ADDR_W-1:0]    exp_addr,
  input  logic [NUM_EXP*DATA_W-1:0]    exp_data,
  input  logic                         MemWriteM,
  input  logic [ADDR_W-1:0]            DataAdrM,
  input  logic [DATA_W-1:0]            WriteDataM,
  output logic                         busy,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout,
  output logic [$clog2(NUM_EXP+1)-1:0] match_cnt,
  output logic [WCNT_W-1:0]            write_cnt,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [DATA_W-1:0]            err_data
);

  localparam int MC_W  = $clog2(NUM_EXP + 1);
  localparam int IDX_W = clog2_sat(NUM_EXP);
  localparam int CYC_W = clog2_sat(TIMEOUT_CYC + 1);
  localparam logic [MC_W-1:0]  LAST_MATCH = MC_W'(NUM_EXP - 1);
  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(TIMEOUT_CYC - 1);

  sb_state_e                   state_q;
  logic [NUM_EXP*ADDR_W-1:0]   tbl_addr_q;
  logic [NUM_EXP*DATA_W-1:0]   tbl_data_q;
  logic [NUM_EXP-1:0]          mask_q, mask_d;
  logic [IDX_W-1:0]            idx_q;
  logic [CYC_W-1:0]            cyc_q;
  logic                        busy_q, pass_q, fail_q, timeout_q;
  logic [MC_W-1:0]             match_cnt_q;
  logic [WCNT_W-1:0]           write_cnt_q, write_cnt_d;
  logic [ADDR_W-1:0]           err_addr_q;
  logic [DATA_W-1:0]           err_data_q;

  logic                        hit, addr_conflict;
  logic [IDX_W-1:0]            hit_idx;
  logic                        wr_hit, wr_conflict, wr_done;

  sb_match_unit #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_EXP(NUM_EXP),
    .ORDERED(ORDERED),
    .IDX_W  (IDX_W)
  ) u_match (
    .tbl_addr_i     (tbl_addr_q),
    .tbl_data_i     (tbl_data_q),
    .mask_i         (mask_q),
    .idx_i          (idx_q),
    .wr_addr_i      (DataAdrM),
    .wr_data_i      (WriteDataM),
    .hit_o          (hit),
    .hit_idx_o      (hit_idx),
    .addr_conflict_o(addr_conflict)
  );

  assign wr_hit      = MemWriteM && hit;
  assign wr_conflict = MemWriteM && addr_conflict;
  assign wr_done     = wr_hit && (match_cnt_q == LAST_MATCH);

  always_comb begin
    write_cnt_d = write_cnt_q;
    if (write_cnt_q != '1) write_cnt_d = write_cnt_q + 1'b1;
    mask_d = mask_q;
    for (int i = 0; i < NUM_EXP; i++) begin
      if (IDX_W'(i) == hit_idx) mask_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SB_IDLE;
      tbl_addr_q  <= '0;
      tbl_data_q  <= '0;
      mask_q      <= '0;
      idx_q       <= '0;
      cyc_q       <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      match_cnt_q <= '0;
      write_cnt_q <= '0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
    end else if (abort) begin
      state_q     <= SB_IDLE;
      mask_q      <= '0;
      idx_q       <= '0;
      cyc_q       <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      match_cnt_q <= '0;
      write_cnt_q <= '0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
    end else begin
      case (state_q)
        SB_RUN: begin
          cyc_q <= cyc_q + 1'b1;
          if (MemWriteM) write_cnt_q <= write_cnt_d;
          if (wr_hit) begin
            mask_q      <= mask_d;
            match_cnt_q <= match_cnt_q + 1'b1;
          end
          // Final match beats both mismatch and timeout; mismatch beats timeout.
          if (wr_done) begin
            state_q <= SB_PASS;
            busy_q  <= 1'b0;
            pass_q  <= 1'b1;
          end else if (wr_conflict) begin
            state_q    <= SB_FAIL;
            busy_q     <= 1'b0;
            fail_q     <= 1'b1;
            err_addr_q <= DataAdrM;
            err_data_q <= WriteDataM;
          end else if (cyc_q == CYC_LAST) begin
            state_q    <= SB_FAIL;
            busy_q     <= 1'b0;
            fail_q     <= 1'b1;
            timeout_q  <= 1'b1;
            err_addr_q <= '0;
            err_data_q <= '0;
          end else if (wr_hit) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          if (start) begin
            state_q     <= SB_RUN;
            tbl_addr_q  <= exp_addr;
            tbl_data_q  <= exp_data;
            mask_q      <= '0;
            idx_q       <= '0;
            cyc_q       <= '0;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            match_cnt_q <= '0;
            write_cnt_q <= '0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign match_cnt = match_cnt_q;
  assign write_cnt = write_cnt_q;
  assign err_addr  = err_addr_q;
  assign err_data  = err_data_q;

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// Scoreboard bench: three scoreboard instances (single-entry/short timeout, ordered, unordered).
module tb_mem_write_scoreboard;

  typedef struct {
    logic        p;
    logic        f;
    logic        t;
    logic [3:0]  mc;
    logic [15:0] wc;
    logic [31:0] ea;
    logic [31:0] ed;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_s [3];
  logic        abort_s [3];
  logic        we_s    [3];
  logic [31:0] adr_s   [3];
  logic [31:0] wd_s    [3];
  logic        busy_s  [3];
  logic        pass_s  [3];
  logic        fail_s  [3];
  logic        to_s    [3];
  logic [15:0] wc_s    [3];
  logic [31:0] ea_s    [3];
  logic [31:0] ed_s    [3];
  logic [3:0]  mc_v    [3];
  logic [0:0]  mc_a;
  logic [1:0]  mc_o, mc_u;

  logic [31:0] tbl1_a, tbl1_d;
  logic [95:0] tbl3_a, tbl3_d;

  assign mc_v[0] = {3'b000, mc_a};
  assign mc_v[1] = {2'b00, mc_o};
  assign mc_v[2] = {2'b00, mc_u};

  mem_write_scoreboard #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(1), .TIMEOUT_CYC(20), .ORDERED(1)) u_a (
    .clk(clk), .reset(reset), .start(start_s[0]), .abort(abort_s[0]),
    .exp_addr(tbl1_a), .exp_data(tbl1_d),
    .MemWriteM(we_s[0]), .DataAdrM(adr_s[0]), .WriteDataM(wd_s[0]),
    .busy(busy_s[0]), .pass(pass_s[0]), .fail(fail_s[0]), .timeout(to_s[0]),
    .match_cnt(mc_a), .write_cnt(wc_s[0]), .err_addr(ea_s[0]), .err_data(ed_s[0]));

  mem_write_scoreboard #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(3), .TIMEOUT_CYC(500), .ORDERED(1)) u_o (
    .clk(clk), .reset(reset), .start(start_s[1]), .abort(abort_s[1]),
    .exp_addr(tbl3_a), .exp_data(tbl3_d),
    .MemWriteM(we_s[1]), .DataAdrM(adr_s[1]), .WriteDataM(wd_s[1]),
    .busy(busy_s[1]), .pass(pass_s[1]), .fail(fail_s[1]), .timeout(to_s[1]),
    .match_cnt(mc_o), .write_cnt(wc_s[1]), .err_addr(ea_s[1]), .err_data(ed_s[1]));

  mem_write_scoreboard #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(3), .TIMEOUT_CYC(500), .ORDERED(0)) u_u (
    .clk(clk), .reset(reset), .start(start_s[2]), .abort(abort_s[2]),
    .exp_addr(tbl3_a), .exp_data(tbl3_d),
    .MemWriteM(we_s[2]), .DataAdrM(adr_s[2]), .WriteDataM(wd_s[2]),
    .busy(busy_s[2]), .pass(pass_s[2]), .fail(fail_s[2]), .timeout(to_s[2]),
    .match_cnt(mc_u), .write_cnt(wc_s[2]), .err_addr(ea_s[2]), .err_data(ed_s[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int k);
    start_s[k] = 1'b1;
    tick();
    start_s[k] = 1'b0;
  endtask

  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d);
    we_s[k]  = 1'b1;
    adr_s[k] = a;
    wd_s[k]  = d;
    tick();
    we_s[k]  = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pass_s[k] || fail_s[k]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (pass_s[k] || fail_s[k]) ok = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({busy_s[k], pass_s[k], fail_s[k], to_s[k], mc_v[k], wc_s[k], ea_s[k], ed_s[k]} !== '0)
        $display("FAIL reset_state dut%0d: busy=%0b pass=%0b fail=%0b to=%0b mc=%0d wc=%0d ea=%0d ed=%0d, want all 0",
                 k, busy_s[k], pass_s[k], fail_s[k], to_s[k], mc_v[k], wc_s[k], ea_s[k], ed_s[k]);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    exp_t e;
    bit   ok;
    do_start(0);
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 4'd1, 16'd2, 32'd0, 32'd0});
    do_write(0, 32'd96, 32'd3);
    repeat (8) tick();
    n_total++;
    if (pass_s[0] !== 1'b0) $display("FAIL single.early_pass got=%0b want=0", pass_s[0]); else n_pass++;
    do_write(0, 32'd100, 32'd7);
    n_total++;
    if (pass_s[0] !== 1'b1) $display("FAIL single.latency pass got=%0b want=1", pass_s[0]); else n_pass++;
    wait_done(0, 4, ok);
    e = exp_q.pop_front();
    n_total++;
    if ({fail_s[0], busy_s[0]} !== {e.f, 1'b0}) $display("FAIL single.fail_busy got=%b want=%b", {fail_s[0], busy_s[0]}, {e.f, 1'b0}); else n_pass++;
    n_total++;
    if (mc_v[0] !== e.mc) $display("FAIL single.match_cnt got=%0d want=%0d", mc_v[0], e.mc); else n_pass++;
    n_total++;
    if (wc_s[0] !== e.wc) $display("FAIL single.write_cnt got=%0d want=%0d", wc_s[0], e.wc); else n_pass++;
  endtask

  task automatic test_ordered();
    exp_t e;
    bit   ok;
    do_start(1);
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 4'd3, 16'd4, 32'd0, 32'd0});
    do_write(1, 32'd84, 32'd2);
    n_total++;
    if ({fail_s[1], mc_v[1]} !== {1'b0, 4'd0}) $display("FAIL ordered.out_of_order_ignored fail=%0b mc=%0d want 0/0", fail_s[1], mc_v[1]); else n_pass++;
    do_write(1, 32'd80, 32'd1);
    do_start(1);
    n_total++;
    if ({busy_s[1], mc_v[1]} !== {1'b1, 4'd1}) $display("FAIL ordered.start_ignored_in_run busy=%0b mc=%0d want 1/1", busy_s[1], mc_v[1]); else n_pass++;
    do_write(1, 32'd84, 32'd2);
    do_write(1, 32'd88, 32'd3);
    wait_done(1, 10, ok);
    n_total++;
    if (!ok) $display("FAIL ordered.done timed out, pass=%0b fail=%0b", pass_s[1], fail_s[1]); else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if ({pass_s[1], fail_s[1]} !== {e.p, e.f}) $display("FAIL ordered.status pass/fail got=%b want=%b", {pass_s[1], fail_s[1]}, {e.p, e.f}); else n_pass++;
    n_total++;
    if ({mc_v[1], wc_s[1]} !== {e.mc, e.wc}) $display("FAIL ordered.counts mc=%0d wc=%0d want %0d/%0d", mc_v[1], wc_s[1], e.mc, e.wc); else n_pass++;
  endtask

  task automatic test_unordered();
    exp_t e;
    bit   ok;
    do_start(2);
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 4'd2, 16'd3, 32'd84, 32'd9});
    do_write(2, 32'd88, 32'd3);
    do_write(2, 32'd80, 32'd1);
    do_write(2, 32'd84, 32'd9);
    wait_done(2, 10, ok);
    n_total++;
    if (!ok) $display("FAIL unordered.done timed out"); else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if ({pass_s[2], fail_s[2], to_s[2]} !== {e.p, e.f, e.t}) $display("FAIL unordered.status p/f/t got=%b want=%b", {pass_s[2], fail_s[2], to_s[2]}, {e.p, e.f, e.t}); else n_pass++;
    n_total++;
    if ({ea_s[2], ed_s[2]} !== {e.ea, e.ed}) $display("FAIL unordered.err_capture got=%0d/%0d want=%0d/%0d", ea_s[2], ed_s[2], e.ea, e.ed); else n_pass++;
    n_total++;
    if (mc_v[2] !== e.mc) $display("FAIL unordered.match_cnt got=%0d want=%0d", mc_v[2], e.mc); else n_pass++;

    do_start(2);
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 4'd3, 16'd4, 32'd0, 32'd0});
    n_total++;
    if ({fail_s[2], busy_s[2], ea_s[2], mc_v[2]} !== {1'b0, 1'b1, 32'd0, 4'd0}) $display("FAIL unordered.restart_clears fail=%0b busy=%0b ea=%0d mc=%0d", fail_s[2], busy_s[2], ea_s[2], mc_v[2]); else n_pass++;
    do_write(2, 32'd80, 32'd1);
    do_write(2, 32'd80, 32'd5);
    n_total++;
    if ({fail_s[2], mc_v[2]} !== {1'b0, 4'd1}) $display("FAIL unordered.repeat_addr_ignored fail=%0b mc=%0d want 0/1", fail_s[2], mc_v[2]); else n_pass++;
    do_write(2, 32'd84, 32'd2);
    do_write(2, 32'd88, 32'd3);
    wait_done(2, 10, ok);
    e = exp_q.pop_front();
    n_total++;
    if ({pass_s[2], fail_s[2], mc_v[2], wc_s[2]} !== {e.p, e.f, e.mc, e.wc}) $display("FAIL unordered.second_run pass=%0b fail=%0b mc=%0d wc=%0d want %0b/%0b/%0d/%0d", pass_s[2], fail_s[2], mc_v[2], wc_s[2], e.p, e.f, e.mc, e.wc); else n_pass++;
  endtask

  task automatic test_timeout();
    exp_t e;
    do_start(0);
    exp_q.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 16'd0, 32'd0, 32'd0});
    repeat (19) tick();
    n_total++;
    if ({fail_s[0], busy_s[0]} !== 2'b01) $display("FAIL timeout.early fail=%0b busy=%0b want 0/1", fail_s[0], busy_s[0]); else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if ({pass_s[0], fail_s[0], to_s[0], busy_s[0]} !== {e.p, e.f, e.t, 1'b0}) $display("FAIL timeout.status p/f/t/busy got=%b want=%b", {pass_s[0], fail_s[0], to_s[0], busy_s[0]}, {e.p, e.f, e.t, 1'b0}); else n_pass++;
    n_total++;
    if ({ea_s[0], ed_s[0]} !== {e.ea, e.ed}) $display("FAIL timeout.err_zero got=%0d/%0d want=0/0", ea_s[0], ed_s[0]); else n_pass++;
  endtask

  task automatic test_timeout_race();
    exp_t e;
    do_start(0);
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 4'd1, 16'd1, 32'd0, 32'd0});
    repeat (19) tick();
    do_write(0, 32'd100, 32'd7);
    e = exp_q.pop_front();
    n_total++;
    if ({pass_s[0], fail_s[0], to_s[0]} !== {e.p, e.f, e.t}) $display("FAIL race.match_wins p/f/t got=%b want=%b", {pass_s[0], fail_s[0], to_s[0]}, {e.p, e.f, e.t}); else n_pass++;

    do_start(0);
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 16'd1, 32'd100, 32'd8});
    repeat (19) tick();
    do_write(0, 32'd100, 32'd8);
    e = exp_q.pop_front();
    n_total++;
    if ({pass_s[0], fail_s[0], to_s[0]} !== {e.p, e.f, e.t}) $display("FAIL race.mismatch_wins p/f/t got=%b want=%b", {pass_s[0], fail_s[0], to_s[0]}, {e.p, e.f, e.t}); else n_pass++;
    n_total++;
    if ({ea_s[0], ed_s[0], wc_s[0]} !== {e.ea, e.ed, e.wc}) $display("FAIL race.err_capture ea=%0d ed=%0d wc=%0d want %0d/%0d/%0d", ea_s[0], ed_s[0], wc_s[0], e.ea, e.ed, e.wc); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    do_start(1);
    do_write(1, 32'd80, 32'd1);
    n_total++;
    if ({busy_s[1], mc_v[1]} !== {1'b1, 4'd1}) $display("FAIL midreset.pre busy=%0b mc=%0d want 1/1", busy_s[1], mc_v[1]); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({busy_s[1], pass_s[1], fail_s[1], to_s[1], mc_v[1], wc_s[1], ea_s[1], ed_s[1]} !== '0)
      $display("FAIL midreset.async_clear busy=%0b pass=%0b fail=%0b mc=%0d wc=%0d want all 0", busy_s[1], pass_s[1], fail_s[1], mc_v[1], wc_s[1]);
    else n_pass++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    do_start(0);
    do_write(0, 32'd100, 32'd7);
    n_total++;
    if (pass_s[0] !== 1'b1) $display("FAIL abort.pre_pass got=%0b want=1", pass_s[0]); else n_pass++;
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    n_total++;
    if ({busy_s[0], pass_s[0], mc_v[0], wc_s[0]} !== '0) $display("FAIL abort.to_idle busy=%0b pass=%0b mc=%0d wc=%0d want 0", busy_s[0], pass_s[0], mc_v[0], wc_s[0]); else n_pass++;
    abort_s[0] = 1'b1;
    start_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    start_s[0] = 1'b0;
    n_total++;
    if (busy_s[0] !== 1'b0) $display("FAIL abort.priority busy got=%0b want=0", busy_s[0]); else n_pass++;
    do_start(0);
    do_write(0, 32'd96, 32'd3);
    n_total++;
    if ({busy_s[0], mc_v[0], wc_s[0]} !== {1'b1, 4'd0, 16'd1}) $display("FAIL abort.rearm busy=%0b mc=%0d wc=%0d want 1/0/1", busy_s[0], mc_v[0], wc_s[0]); else n_pass++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    tbl1_a = 32'd100;
    tbl1_d = 32'd7;
    tbl3_a = {32'd88, 32'd84, 32'd80};
    tbl3_d = {32'd3, 32'd2, 32'd1};
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      abort_s[k] = 1'b0;
      we_s[k]    = 1'b0;
      adr_s[k]   = '0;
      wd_s[k]    = '0;
    end
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_single();
    test_ordered();
    test_unordered();
    test_timeout();
    test_timeout_race();
    test_reset_mid_run();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
